banco_registros_param: RTL
==========================

# banco_registros_param

Parametrised register bank: PROFUNDIDAD registers of ANCHO bits, one write port, two registered read ports with write-through bypass, and a ranged clear sequencer that zeroes a contiguous, optionally wrapping, address range at one register per cycle. It is the general-purpose register storage of the datapath and replaces the fixed 8x16 bank. Write data and addresses come from the control unit. RtaA/RtaB feed the ALU operand stage.

## Interface
- ANCHO, 16, data width in bits (>=1)
- PROFUNDIDAD, 8, number of registers (power of 2, >=2)
- CERO_FIJO, 0, when 1 register 0 always reads 0 and writes to it are discarded
- DIR (derived, not overridable) = $clog2(PROFUNDIDAD)
- Reloj  in  1  single clock, all state updates on rising edge
- Reiniciar  in  1  synchronous, active-high reset
- Habilitar  in  1  write enable
- DireccionEscritura  in  DIR  write address
- Tupla  in  ANCHO  write data
- DireccionA, DireccionB  in  DIR  read addresses
- Limpiar  in  1  start ranged clear (sampled only when idle)
- DireccionInicio, DireccionFin  in  DIR  clear range bounds, sampled with Limpiar
- RtaA, RtaB  out  ANCHO  registered read data
- Ocupado  out  1  clear sweep in progress
- Hecho  out  1  one-cycle pulse after the last register of a sweep is cleared

## Operation
- Reset (Reiniciar=1 at an edge): all registers, RtaA, RtaB, Ocupado and Hecho become 0. The FSM goes to REPOSO. This overrides every other input in that cycle.
- Write: at an edge with Habilitar=1 and state REPOSO, mem[DireccionEscritura] <= Tupla. If CERO_FIJO=1 and the address is 0, the write is dropped.
- Read: RtaX <= value of mem[DireccionX] as it stands after this edge's update:
  - an accepted write to DireccionX returns Tupla (bypass);
  - a sweep clearing DireccionX this edge returns 0;
  - CERO_FIJO with address 0 returns 0.
- FSM states: REPOSO and LIMPIANDO.
  - REPOSO with Limpiar=1: latch puntero<=DireccionInicio and fin<=DireccionFin, then go to LIMPIANDO.
  - A write presented in the same cycle as Limpiar is still performed.
  - LIMPIANDO, each edge: mem[puntero] <= 0.
    - If puntero==fin: go to REPOSO and pulse Hecho.
    - Else: puntero <= puntero+1 mod PROFUNDIDAD.
  - Range wrap: Inicio>Fin clears Inicio..PROFUNDIDAD-1 then 0..Fin. Inicio==Fin clears exactly one register.
  - Limpiar while in LIMPIANDO is ignored; it does not queue.
  - Habilitar while in LIMPIANDO: the write is discarded; there is no error flag, and the control unit must watch Ocupado.
  - Reads remain fully functional during a sweep.
- Reiniciar mid-sweep aborts the sweep: the FSM returns to REPOSO and Hecho stays 0.

## Timing
- Read latency is 1 cycle: the address presented before edge n has its data valid after edge n.
- Write is visible to reads at the same edge through the bypass, so there is 0-cycle read-after-write hazard.
- Sweep of K registers, K = ((Fin-Inicio) mod PROFUNDIDAD)+1:
  - Limpiar sampled at edge e0 sets Ocupado=1 after e0.
  - Edges e1..eK each clear one register.
  - After eK: Ocupado=0 and Hecho=1 for exactly one cycle (it drops after eK+1).
- A new Limpiar can be accepted at eK+1 at the earliest, because the FSM is in REPOSO after eK.
- Both outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package banco_pkg: FSM state encoding (REPOSO, LIMPIANDO) and the default ANCHO/PROFUNDIDAD constants.
- Sub-module secuenciador_limpieza holds the FSM, puntero and fin, and outputs Ocupado, Hecho, a clear-enable and the clear address.
- The top level holds the storage array, write gating and read/bypass muxing.

## Test plan
- Reset, then write 16'h00A5 to r7 and 16'h1234 to r4 on consecutive cycles, with DireccionA=7 and DireccionB=4 -> RtaA=00A5 one cycle after the first write edge, RtaB=1234 after the second.
- Bypass: Habilitar=1, write r3=16'hBEEF with DireccionA=3 in the same cycle -> RtaA=BEEF after that edge, not the old value.
- Wrapping sweep, PROFUNDIDAD=8, all registers pre-loaded with 16'hFFFF, Inicio=6, Fin=1:
  - Ocupado is high for 4 cycles and Hecho pulses once.
  - r6, r7, r0, r1 read 0; r2..r5 still read FFFF.
- Write during sweep: Habilitar=1 to r3 at e2 of a 0..3 sweep -> r3 reads 0 afterwards. Limpiar at e2 is ignored and the sweep length is still 4.
- Reiniciar at e2 of a 5-register sweep -> all registers 0, Ocupado=0 next cycle, Hecho never asserted.
- CERO_FIJO=1: write 16'h7777 to r0 -> RtaA with DireccionA=0 reads 0. Reads and writes of r1 are unaffected.

Source files
------------

// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared types and default sizes for the register bank
package banco_pkg;

  localparam int ANCHO_DEF       = 16;
  localparam int PROFUNDIDAD_DEF = 8;

  typedef enum logic {
    REPOSO    = 1'b0,
    LIMPIANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/secuenciador_limpieza.sv
// rtl/secuenciador_limpieza.sv - ranged clear sweep FSM, one register per cycle
module secuenciador_limpieza
  import banco_pkg::*;
#(
  parameter int DIR = 3
) (
  input  logic           reloj,
  input  logic           reiniciar,
  input  logic           limpiar,
  input  logic [DIR-1:0] direccion_inicio,
  input  logic [DIR-1:0] direccion_fin,
  output logic           ocupado,
  output logic           hecho,
  output logic           borrar,
  output logic [DIR-1:0] direccion_borrar
);

  estado_t        estado;
  logic [DIR-1:0] puntero;
  logic [DIR-1:0] fin;

  // Sweep control: latch the range when idle, walk the pointer (wrapping) until it meets fin
  always_ff @(posedge reloj) begin
    if (reiniciar) begin
      estado  <= REPOSO;
      puntero <= '0;
      fin     <= '0;
      ocupado <= 1'b0;
      hecho   <= 1'b0;
    end else begin
      hecho <= 1'b0;
      case (estado)
        REPOSO: begin
          if (limpiar) begin
            puntero <= direccion_inicio;
            fin     <= direccion_fin;
            estado  <= LIMPIANDO;
            ocupado <= 1'b1;
          end
        end
        LIMPIANDO: begin
          if (puntero == fin) begin
            estado  <= REPOSO;
            ocupado <= 1'b0;
            hecho   <= 1'b1;
          end else begin
            puntero <= puntero + DIR'(1);
          end
        end
        default: begin
          estado  <= REPOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

  // The register under the pointer is cleared on every edge spent in LIMPIANDO
  assign borrar           = (estado == LIMPIANDO);
  assign direccion_borrar = puntero;

endmodule

// File: rtl/banco_registros_param.sv
// rtl/banco_registros_param.sv - parametrised register bank with bypassed reads and ranged clear
module banco_registros_param
  import banco_pkg::*;
#(
  parameter  int ANCHO       = ANCHO_DEF,
  parameter  int PROFUNDIDAD = PROFUNDIDAD_DEF,
  parameter  int CERO_FIJO   = 0,
  localparam int DIR         = $clog2(PROFUNDIDAD)
) (
  input  logic             Reloj,
  input  logic             Reiniciar,
  input  logic             Habilitar,
  input  logic [DIR-1:0]   DireccionEscritura,
  input  logic [ANCHO-1:0] Tupla,
  input  logic [DIR-1:0]   DireccionA,
  input  logic [DIR-1:0]   DireccionB,
  input  logic             Limpiar,
  input  logic [DIR-1:0]   DireccionInicio,
  input  logic [DIR-1:0]   DireccionFin,
  output logic [ANCHO-1:0] RtaA,
  output logic [ANCHO-1:0] RtaB,
  output logic             Ocupado,
  output logic             Hecho
);

  localparam bit CERO = (CERO_FIJO != 0);

  logic [ANCHO-1:0] mem [PROFUNDIDAD];
  logic             borrar;
  logic [DIR-1:0]   direccion_borrar;
  logic             escribir;
  logic [ANCHO-1:0] lectura_a;
  logic [ANCHO-1:0] lectura_b;

  secuenciador_limpieza #(
    .DIR(DIR)
  ) u_secuenciador (
    .reloj            (Reloj),
    .reiniciar        (Reiniciar),
    .limpiar          (Limpiar),
    .direccion_inicio (DireccionInicio),
    .direccion_fin    (DireccionFin),
    .ocupado          (Ocupado),
    .hecho            (Hecho),
    .borrar           (borrar),
    .direccion_borrar (direccion_borrar)
  );

  // Writes are refused while a sweep owns the array, and always for a hard-wired r0
  assign escribir = Habilitar && !borrar && !(CERO && (DireccionEscritura == '0));

  // Returns what the addressed register will hold after this edge
  function automatic logic [ANCHO-1:0] leer(input logic [DIR-1:0] dir);
    if (CERO && (dir == '0))                   return '0;
    if (escribir && (DireccionEscritura == dir)) return Tupla;
    if (borrar && (direccion_borrar == dir))     return '0;
    return mem[dir];
  endfunction

  // Read muxing with write-through and clear-through bypass
  always_comb begin
    lectura_a = leer(DireccionA);
    lectura_b = leer(DireccionB);
  end

  // Storage update and registered read ports
  always_ff @(posedge Reloj) begin
    if (Reiniciar) begin
      for (int i = 0; i < PROFUNDIDAD; i++) mem[i] <= '0;
      RtaA <= '0;
      RtaB <= '0;
    end else begin
      if (escribir) mem[DireccionEscritura] <= Tupla;
      if (borrar)   mem[direccion_borrar]   <= '0;
      RtaA <= lectura_a;
      RtaB <= lectura_b;
    end
  end

endmodule
